stage_m: RTL and testbench

STAGE_M -- requirements
Module: stage_M

---
 rtl/stage_m_pkg.sv | 38 +++
 rtl/stage_m_store_align.sv | 50 +++++
 rtl/stage_m.sv | 215 +++++++++++++++++++++
 tb/tb_stage_m.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_m_pkg.sv
// Shared definitions for the memory (M) stage.
// Holds the memory-access ALU codes, the default word address of the
// hardware cycle counter, the stage FSM state type and the alignment
// helper used to decide whether an access must bypass memory.
package stage_m_pkg;

  // ALU operation codes shared with the execute stage.
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  // Word address at which loads return the hardware cycle counter.
  localparam logic [31:0] HC_ADDR_DEFAULT = 32'hFFFF_FF00;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Halfword ops need bit 0 clear, word ops need both low bits clear.
  function automatic logic misaligned_f(input logic [5:0] alucode,
                                        input logic [1:0] addr_lo);
    logic r;
    case (alucode)
      ALU_LH, ALU_LHU, ALU_SH: r = addr_lo[0];
      ALU_LW, ALU_SW:          r = (addr_lo != 2'b00);
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_m_store_align.sv
// store_align: places store data on the byte lanes of the 32-bit memory bus.
// Ports:
//   i_is_store   - op is a store (otherwise write enable/strobes are zero)
//   i_alucode    - selects byte / halfword / word store
//   i_addr_lo    - low two address bits (lane select)
//   i_store_data - register value to be stored
//   o_we         - memory write enable
//   o_wdata      - lane-replicated write data
//   o_wstrb      - byte strobes
module store_align
  import stage_m_pkg::*;
(
  input  logic        i_is_store,
  input  logic [5:0]  i_alucode,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  output logic        o_we,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  // Replicate the narrow datum across the bus and strobe only its lanes.
  always_comb begin
    o_we    = 1'b0;
    o_wdata = 32'h0000_0000;
    o_wstrb = 4'b0000;
    if (i_is_store) begin
      o_we = 1'b1;
      case (i_alucode)
        ALU_SB: begin
          o_wdata = {4{i_store_data[7:0]}};
          o_wstrb = 4'b0001 << i_addr_lo;
        end
        ALU_SH: begin
          o_wdata = {2{i_store_data[15:0]}};
          o_wstrb = 4'b0011 << i_addr_lo;
        end
        default: begin
          o_wdata = i_store_data;
          o_wstrb = 4'b1111;
        end
      endcase
    end else begin
      o_we    = 1'b0;
      o_wdata = 32'h0000_0000;
      o_wstrb = 4'b0000;
    end
  end

endmodule

// File: rtl/stage_m.sv
// stage_m: memory stage between execute and writeback.
// Accepts one execute result per handshake. Non-memory ops, accesses to the
// hardware cycle counter and misaligned accesses complete in one cycle;
// aligned ordinary loads/stores issue a request on the data-memory port and
// complete one cycle after mem_ack.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid / in_ready      - upstream handshake
//   alu_result .. reg_we     - execute-stage results
//   mem_*                    - data-memory request/response port
//   out_valid, w_*           - registered results for writeback
module stage_m
  import stage_m_pkg::*;
#(
  parameter logic [31:0] HC_ADDR = HC_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [5:0]  alucode,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [4:0]  rd,
  input  logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] w_alu_result,
  output logic [31:0] w_mem_data,
  output logic        w_is_load,
  output logic [5:0]  w_alucode,
  output logic [4:0]  w_byte_offset,
  output logic        w_is_hardware,
  output logic [31:0] w_hc_data,
  output logic [4:0]  w_rd,
  output logic        w_reg_we,
  output logic        w_misaligned
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_hc_cnt;

  logic        w_is_mem;
  logic        w_is_hw;
  logic        w_mis;
  logic        w_xfer;
  logic        w_to_mem;
  logic        w_direct;
  logic        w_ack;

  logic        w_sa_we;
  logic [31:0] w_sa_wdata;
  logic [3:0]  w_sa_wstrb;

  // Fields of an in-flight memory access, presented to writeback on ack.
  logic [31:0] r_p_alu_result;
  logic [5:0]  r_p_alucode;
  logic        r_p_is_load;
  logic [4:0]  r_p_rd;
  logic        r_p_reg_we;
  logic [31:0] r_p_hc;

  assign in_ready = (r_state == ST_IDLE);
  assign w_xfer   = in_valid && in_ready;
  assign w_is_mem = is_load || is_store;
  assign w_is_hw  = w_is_mem && (alu_result[31:2] == HC_ADDR[31:2]);
  assign w_mis    = w_is_mem && misaligned_f(alucode, alu_result[1:0]);
  assign w_to_mem = w_xfer && w_is_mem && !w_is_hw && !w_mis;
  assign w_direct = w_xfer && !w_to_mem;
  // An ack only counts while a request is outstanding.
  assign w_ack    = (r_state == ST_WAIT) && mem_ack;

  store_align u_store_align (
    .i_is_store   (is_store),
    .i_alucode    (alucode),
    .i_addr_lo    (alu_result[1:0]),
    .i_store_data (store_data),
    .o_we         (w_sa_we),
    .o_wdata      (w_sa_wdata),
    .o_wstrb      (w_sa_wstrb)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_to_mem) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc_cnt <= 32'h0000_0000;
    end else begin
      r_hc_cnt <= r_hc_cnt + 32'd1;
    end
  end

  // Memory request registers: loaded on issue, held until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
    end else if (w_to_mem) begin
      mem_req   <= 1'b1;
      mem_we    <= w_sa_we;
      mem_addr  <= {alu_result[31:2], 2'b00};
      mem_wdata <= w_sa_wdata;
      mem_wstrb <= w_sa_wstrb;
    end else if (w_ack) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
    end
  end

  // Capture the accepted op while its memory access is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_alu_result <= 32'h0000_0000;
      r_p_alucode    <= 6'd0;
      r_p_is_load    <= 1'b0;
      r_p_rd         <= 5'd0;
      r_p_reg_we     <= 1'b0;
      r_p_hc         <= 32'h0000_0000;
    end else if (w_to_mem) begin
      r_p_alu_result <= alu_result;
      r_p_alucode    <= alucode;
      r_p_is_load    <= is_load;
      r_p_rd         <= rd;
      r_p_reg_we     <= reg_we;
      r_p_hc         <= r_hc_cnt;
    end
  end

  // Writeback registers: change only in the cycle before out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      w_alu_result  <= 32'h0000_0000;
      w_mem_data    <= 32'h0000_0000;
      w_is_load     <= 1'b0;
      w_alucode     <= 6'd0;
      w_byte_offset <= 5'd0;
      w_is_hardware <= 1'b0;
      w_hc_data     <= 32'h0000_0000;
      w_rd          <= 5'd0;
      w_reg_we      <= 1'b0;
      w_misaligned  <= 1'b0;
    end else if (w_direct) begin
      out_valid     <= 1'b1;
      w_alu_result  <= alu_result;
      w_mem_data    <= 32'h0000_0000;
      w_is_load     <= is_load;
      w_alucode     <= alucode;
      w_byte_offset <= {alu_result[1:0], 3'b000};
      w_is_hardware <= w_is_hw;
      w_hc_data     <= r_hc_cnt;
      w_rd          <= rd;
      w_reg_we      <= reg_we && !w_mis;
      w_misaligned  <= w_mis;
    end else if (w_ack) begin
      out_valid     <= 1'b1;
      w_alu_result  <= r_p_alu_result;
      w_mem_data    <= mem_rdata;
      w_is_load     <= r_p_is_load;
      w_alucode     <= r_p_alucode;
      w_byte_offset <= {r_p_alu_result[1:0], 3'b000};
      w_is_hardware <= 1'b0;
      w_hc_data     <= r_p_hc;
      w_rd          <= r_p_rd;
      w_reg_we      <= r_p_reg_we;
      w_misaligned  <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_m.sv
// Self-checking bench for stage_m: directed scenarios followed by random
// ops checked against an arithmetic reference model.
module tb_stage_m;
  import stage_m_pkg::*;

  localparam logic [31:0] HC = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [5:0]  alucode;
  logic        is_load;
  logic        is_store;
  logic [4:0]  rd;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] w_alu_result;
  logic [31:0] w_mem_data;
  logic        w_is_load;
  logic [5:0]  w_alucode;
  logic [4:0]  w_byte_offset;
  logic        w_is_hardware;
  logic [31:0] w_hc_data;
  logic [4:0]  w_rd;
  logic        w_reg_we;
  logic        w_misaligned;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] base_val = 32'h0;
  int          base_cyc = 0;

  stage_m #(.HC_ADDR(HC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .alucode(alucode),
    .is_load(is_load), .is_store(is_store), .rd(rd), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid),
    .w_alu_result(w_alu_result), .w_mem_data(w_mem_data),
    .w_is_load(w_is_load), .w_alucode(w_alucode),
    .w_byte_offset(w_byte_offset), .w_is_hardware(w_is_hardware),
    .w_hc_data(w_hc_data), .w_rd(w_rd), .w_reg_we(w_reg_we),
    .w_misaligned(w_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        mem_path;
    logic        hw;
    logic        mis;
    logic        we;
    logic [31:0] addr_w;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        reg_we;
    logic [4:0]  boff;
  } exp_t;

  // Reference model: access size in bytes decides alignment and lanes.
  function automatic exp_t model(input logic [5:0] code, input logic ld,
                                 input logic st, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic we_i);
    exp_t e;
    int sz;
    int lo;
    sz = 0;
    if (code == ALU_LB || code == ALU_LBU || code == ALU_SB) sz = 1;
    else if (code == ALU_LH || code == ALU_LHU || code == ALU_SH) sz = 2;
    else if (code == ALU_LW || code == ALU_SW) sz = 4;
    lo = int'(addr % 32'd4);
    e.hw     = (ld || st) && ((addr / 32'd4) == (HC / 32'd4));
    e.mis    = (ld || st) && (sz > 1) && ((lo % sz) != 0);
    e.mem_path = (ld || st) && !e.hw && !e.mis;
    e.addr_w = addr - 32'(lo);
    e.we     = st;
    if (!st)          e.wdata = 32'h0;
    else if (sz == 1) e.wdata = {4{sdata[7:0]}};
    else if (sz == 2) e.wdata = {2{sdata[15:0]}};
    else              e.wdata = sdata;
    e.wstrb  = st ? 4'(((1 << sz) - 1) << lo) : 4'b0000;
    e.reg_we = e.mis ? 1'b0 : we_i;
    e.boff   = 5'(lo * 8);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] addr, input logic ld,
                       input logic [5:0] code, input exp_t e, input logic [31:0] hc,
                       input logic [4:0] rd_i, input logic [31:0] mdata);
    chk({tag, ".out_valid"},    out_valid, 32'd1);
    chk({tag, ".w_alu_result"}, w_alu_result, addr);
    chk({tag, ".w_is_load"},    w_is_load, ld);
    chk({tag, ".w_alucode"},    w_alucode, code);
    chk({tag, ".w_byte_off"},   w_byte_offset, e.boff);
    chk({tag, ".w_is_hw"},      w_is_hardware, e.hw);
    chk({tag, ".w_hc_data"},    w_hc_data, hc);
    chk({tag, ".w_rd"},         w_rd, rd_i);
    chk({tag, ".w_reg_we"},     w_reg_we, e.reg_we);
    chk({tag, ".w_misaligned"}, w_misaligned, e.mis);
    chk({tag, ".w_mem_data"},   w_mem_data, mdata);
  endtask

  task automatic chk_req(input string tag, input exp_t e);
    chk({tag, ".mem_req"},   mem_req, 32'd1);
    chk({tag, ".mem_we"},    mem_we, e.we);
    chk({tag, ".mem_addr"},  mem_addr, e.addr_w);
    chk({tag, ".mem_wdata"}, mem_wdata, e.wdata);
    chk({tag, ".mem_wstrb"}, mem_wstrb, e.wstrb);
    chk({tag, ".in_ready"},  in_ready, 32'd0);
    chk({tag, ".out_valid"}, out_valid, 32'd0);
  endtask

  task automatic scramble();
    alu_result = $urandom;
    store_data = $urandom;
    alucode    = 6'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    rd         = 5'($urandom);
    reg_we     = 1'($urandom);
  endtask

  // Issue one op at a negedge and follow it to completion.
  task automatic do_op(input string tag, input logic [5:0] code, input logic ld,
                       input logic st, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd_i, input logic we_i, input int ack_dly,
                       input logic [31:0] rdata_v);
    exp_t e;
    logic [31:0] hc_exp;
    e = model(code, ld, st, addr, sdata, we_i);
    hc_exp = base_val + 32'(cyc - base_cyc);
    chk({tag, ".in_ready0"}, in_ready, 32'd1);
    alu_result = addr; store_data = sdata; alucode = code;
    is_load = ld; is_store = st; rd = rd_i; reg_we = we_i; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    if (!e.mem_path) begin
      chk({tag, ".no_req"}, mem_req, 32'd0);
      chk_w(tag, addr, ld, code, e, hc_exp, rd_i, 32'h0);
      @(negedge clk);
      chk({tag, ".ov_drop"}, out_valid, 32'd0);
    end else begin
      chk_req({tag, ".req0"}, e);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        chk_req({tag, ".hold"}, e);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata_v;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      chk({tag, ".req_drop"}, mem_req, 32'd0);
      chk({tag, ".ready_back"}, in_ready, 32'd1);
      chk_w(tag, addr, ld, code, e, hc_exp, rd_i, rdata_v);
      @(negedge clk);
      chk({tag, ".ov_drop"}, out_valid, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_val = 32'h0;
    base_cyc = cyc;
  endtask

  logic [5:0]  mem_codes [8];
  logic [5:0]  code_r;
  logic [31:0] addr_r;
  int          sel;

  initial begin
    mem_codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    scramble();
    do_reset();

    // Reset state.
    chk("rst.in_ready",  in_ready, 32'd1);
    chk("rst.out_valid", out_valid, 32'd0);
    chk("rst.mem_req",   mem_req, 32'd0);
    chk("rst.mem_we",    mem_we, 32'd0);
    chk("rst.mem_addr",  mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_wstrb", mem_wstrb, 32'd0);
    chk("rst.w_alu",     w_alu_result, 32'd0);
    chk("rst.w_hc",      w_hc_data, 32'd0);
    chk("rst.w_reg_we",  w_reg_we, 32'd0);

    // Idle ack is ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack.out_valid", out_valid, 32'd0);
    chk("idle_ack.mem_req",   mem_req, 32'd0);

    do_op("add", ALU_ADD, 1'b0, 1'b0, 32'h1234, 32'h5555, 5'd3, 1'b1, 0, 32'h0);
    do_op("sb",  ALU_SB,  1'b0, 1'b1, 32'h103, 32'hAB, 5'd0, 1'b0, 3, 32'h0BAD_F00D);
    do_op("lh",  ALU_LH,  1'b1, 1'b0, 32'h202, 32'h0, 5'd7, 1'b1, 0, 32'h8001_0000);
    do_op("sw_mis", ALU_SW, 1'b0, 1'b1, 32'h102, 32'hDEAD_BEEF, 5'd9, 1'b1, 0, 32'h0);

    // Hardware counter read at counter value 5.
    do_reset();
    for (int i = 0; i < 5; i++) @(negedge clk);
    do_op("hc5", ALU_LW, 1'b1, 1'b0, HC, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    do_op("hc_st", ALU_SW, 1'b0, 1'b1, HC, 32'h1234_5678, 5'd0, 1'b0, 0, 32'h0);

    // Counter wrap from a preloaded value.
    force dut.r_hc_cnt = 32'hFFFF_FFFE;
    base_val = 32'hFFFF_FFFE;
    base_cyc = cyc;
    #1 release dut.r_hc_cnt;
    do_op("hc_pre",  ALU_LW, 1'b1, 1'b0, HC, 32'h0, 5'd1, 1'b1, 0, 32'h0);
    do_op("hc_wrap", ALU_LW, 1'b1, 1'b0, HC, 32'h0, 5'd2, 1'b1, 0, 32'h0);

    // Reset during WAIT abandons the access.
    alu_result = 32'h40; store_data = 32'h1111_2222; alucode = ALU_SW;
    is_load = 1'b0; is_store = 1'b1; rd = 5'd0; reg_we = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstwait.req", mem_req, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base_val = 32'h0;
    base_cyc = cyc;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rstwait.mem_req",   mem_req, 32'd0);
    chk("rstwait.in_ready",  in_ready, 32'd1);
    chk("rstwait.out_valid", out_valid, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstwait.out_valid2", out_valid, 32'd0);

    // Random ops against the reference model.
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 8);
      addr_r = $urandom;
      if ($urandom_range(0, 3) == 0) addr_r = (HC / 32'd4) * 32'd4 + (addr_r % 32'd4);
      if ($urandom_range(0, 1) == 1) addr_r = addr_r - (addr_r % 32'd4);
      if (sel == 0) begin
        code_r = 6'($urandom_range(0, 19));
        do_op("rnd_alu", code_r, 1'b0, 1'b0, addr_r, $urandom, 5'($urandom),
              1'($urandom), 0, 32'h0);
      end else begin
        code_r = mem_codes[sel - 1];
        do_op("rnd_mem", code_r, (sel <= 5), (sel > 5), addr_r, $urandom,
              5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
